// File: rtl/tlul_host_arb.sv
// M-to-1 TileLink-UL host arbiter: round-robin A channel with grant lock,
// D responses routed back through an in-order FIFO of granted host indices.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int M      = 2,
    parameter int MaxOut = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  tl_h2d_t                      tl_h_i [M],
    output tl_d2h_t                      tl_h_o [M],
    output tl_h2d_t                      tl_d_o,
    input  tl_d2h_t                      tl_d_i,
    output logic [$clog2(MaxOut+1)-1:0]  outstanding_o,
    output logic                         spurious_o
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = $clog2(MaxOut);
    localparam int CW = $clog2(MaxOut + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_q, lock_q, grant, head;
    logic [IW-1:0] fifo_q [MaxOut];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          full, empty, any_valid, a_active;
    logic          a_accept, d_pop, d_ready_dev;
    int            j;

    assign full  = (cnt_q == CW'(MaxOut));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    // Walk downward so the lowest offset from rr_q wins.
    always_comb begin
        grant     = rr_q;
        any_valid = 1'b0;
        j         = 0;
        for (int i = M - 1; i >= 0; i--) begin
            j = (int'(rr_q) + i) % M;
            if (tl_h_i[j].a_valid) begin
                grant     = IW'(j);
                any_valid = 1'b1;
            end
        end
        if (state_q == LOCKED) grant = lock_q;
    end

    assign a_active = rst_ni &
                      ((state_q == LOCKED) | (~full & any_valid));

    always_comb begin
        tl_d_o = '0;
        if (a_active) tl_d_o = tl_h_i[grant];
        tl_d_o.d_ready = d_ready_dev;
    end

    assign a_accept    = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_ready_dev = rst_ni & (empty | tl_h_i[head].d_ready);
    assign d_pop       = tl_d_i.d_valid & d_ready_dev & ~empty;
    assign spurious_o  = rst_ni & empty & tl_d_i.d_valid;
    assign outstanding_o = cnt_q;

    always_comb begin
        for (int h = 0; h < M; h++) begin
            tl_h_o[h] = tl_d_i;
            tl_h_o[h].a_ready = a_active & (grant == IW'(h)) &
                                tl_d_i.a_ready;
            tl_h_o[h].d_valid = rst_ni & ~empty & (head == IW'(h)) &
                                tl_d_i.d_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (tl_d_o.a_valid & ~tl_d_i.a_ready) state_d = LOCKED;
            LOCKED: if (a_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == LOCKED) lock_q <= grant;
            if (a_accept) begin
                rr_q   <= (grant == IW'(M - 1)) ? '0 : grant + 1'b1;
                wptr_q <= wptr_q + 1'b1;
            end
            if (d_pop) rptr_q <= rptr_q + 1'b1;
            if (a_accept != d_pop)
                cnt_q <= a_accept ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    // Index storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk_i) begin
        if (a_accept) fifo_q[wptr_q] <= grant;
    end
endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed self-checking bench for tlul_host_arb (M=2, MaxOut=4).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    tl_h2d_t    h_i [2];
    tl_d2h_t    h_o [2];
    tl_h2d_t    d_o;
    tl_d2h_t    d_i;
    logic [2:0] outst;
    logic       spur;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tlul_host_arb #(.M(2), .MaxOut(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .tl_h_i        (h_i),
        .tl_h_o        (h_o),
        .tl_d_o        (d_o),
        .tl_d_i        (d_i),
        .outstanding_o (outst),
        .spurious_o    (spur)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        h_i[0].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        d_i.d_valid = 1'b1;
        cyc();
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL rst_outst: got %0d exp 0", outst); end
        checks++; if (d_o.a_valid !== 1'b0) begin errors++; $display("FAIL rst_dev_a_valid: got %b exp 0", d_o.a_valid); end
        checks++; if (d_o.d_ready !== 1'b0) begin errors++; $display("FAIL rst_dev_d_ready: got %b exp 0", d_o.d_ready); end
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL rst_h0_a_ready: got %b exp 0", h_o[0].a_ready); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rst_h0_d_valid: got %b exp 0", h_o[0].d_valid); end
        checks++; if (spur !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %b exp 0", spur); end
        cyc();
        rst_ni = 1'b1;
        h_i[0].a_valid = 1'b0;
        d_i.a_ready = 1'b0;
        d_i.d_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        h_i[0].a_valid = 1'b1;
        h_i[1].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        #1;
        checks++; if (d_o.a_source !== 8'h10) begin errors++; $display("FAIL rr_grant0: got %0h exp 10", d_o.a_source); end
        checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL rr_h0_ready: got %b exp 1", h_o[0].a_ready); end
        checks++; if (h_o[1].a_ready !== 1'b0) begin errors++; $display("FAIL rr_h1_blocked: got %b exp 0", h_o[1].a_ready); end
        cyc();
        #1;
        checks++; if (d_o.a_source !== 8'h21) begin errors++; $display("FAIL rr_grant1: got %0h exp 21", d_o.a_source); end
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL rr_h0_blocked: got %b exp 0", h_o[0].a_ready); end
        checks++; if (outst !== 3'd1) begin errors++; $display("FAIL rr_outst1: got %0d exp 1", outst); end
        cyc();
        d_i.d_valid = 1'b1;
        d_i.d_data = 32'hAA;
        #1;
        checks++; if (d_o.a_source !== 8'h10) begin errors++; $display("FAIL rr_grant2: got %0h exp 10", d_o.a_source); end
        checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL rr_d0_valid: got %b exp 1", h_o[0].d_valid); end
        checks++; if (h_o[1].d_valid !== 1'b0) begin errors++; $display("FAIL rr_d0_other: got %b exp 0", h_o[1].d_valid); end
        checks++; if (h_o[0].d_data !== 32'hAA) begin errors++; $display("FAIL rr_d0_data: got %0h exp aa", h_o[0].d_data); end
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL rr_outst2: got %0d exp 2", outst); end
        cyc();
        h_i[0].a_valid = 1'b0;
        h_i[1].a_valid = 1'b0;
        d_i.d_data = 32'hBB;
        #1;
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL rr_push_pop: got %0d exp 2", outst); end
        checks++; if (h_o[1].d_valid !== 1'b1) begin errors++; $display("FAIL rr_d1_valid: got %b exp 1", h_o[1].d_valid); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rr_d1_other: got %b exp 0", h_o[0].d_valid); end
        cyc();
        #1;
        checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL rr_d2_valid: got %b exp 1", h_o[0].d_valid); end
        checks++; if (outst !== 3'd1) begin errors++; $display("FAIL rr_outst3: got %0d exp 1", outst); end
        cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL rr_drained: got %0d exp 0", outst); end
    endtask

    task automatic test_lock();
        h_i[1].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        #1;
        checks++; if (h_o[1].a_ready !== 1'b1) begin errors++; $display("FAIL lk_pre_accept: got %b exp 1", h_o[1].a_ready); end
        cyc();
        d_i.a_ready = 1'b0;
        #1;
        checks++; if (d_o.a_valid !== 1'b1) begin errors++; $display("FAIL lk_offer: got %b exp 1", d_o.a_valid); end
        checks++; if (d_o.a_source !== 8'h21) begin errors++; $display("FAIL lk_src0: got %0h exp 21", d_o.a_source); end
        cyc();
        h_i[0].a_valid = 1'b1;
        #1;
        checks++; if (d_o.a_source !== 8'h21) begin errors++; $display("FAIL lk_src1: got %0h exp 21", d_o.a_source); end
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL lk_h0_blocked: got %b exp 0", h_o[0].a_ready); end
        cyc();
        #1;
        checks++; if (d_o.a_source !== 8'h21) begin errors++; $display("FAIL lk_src2: got %0h exp 21", d_o.a_source); end
        cyc();
        d_i.a_ready = 1'b1;
        #1;
        checks++; if (h_o[1].a_ready !== 1'b1) begin errors++; $display("FAIL lk_h1_accept: got %b exp 1", h_o[1].a_ready); end
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL lk_h0_wait: got %b exp 0", h_o[0].a_ready); end
        cyc();
        #1;
        checks++; if (d_o.a_source !== 8'h10) begin errors++; $display("FAIL lk_h0_next: got %0h exp 10", d_o.a_source); end
        checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL lk_h0_ready: got %b exp 1", h_o[0].a_ready); end
        cyc();
        h_i[0].a_valid = 1'b0;
        h_i[1].a_valid = 1'b0;
        d_i.d_valid = 1'b1;
        #1;
        checks++; if (outst !== 3'd3) begin errors++; $display("FAIL lk_outst3: got %0d exp 3", outst); end
        checks++; if (h_o[1].d_valid !== 1'b1) begin errors++; $display("FAIL lk_ord0: got %b exp 1", h_o[1].d_valid); end
        cyc();
        #1;
        checks++; if (h_o[1].d_valid !== 1'b1) begin errors++; $display("FAIL lk_ord1: got %b exp 1", h_o[1].d_valid); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL lk_ord1_other: got %b exp 0", h_o[0].d_valid); end
        cyc();
        #1;
        checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL lk_ord2: got %b exp 1", h_o[0].d_valid); end
        cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL lk_drained: got %0d exp 0", outst); end
    endtask

    task automatic test_full();
        h_i[0].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL fl_accept%0d: got %b exp 1", k, h_o[0].a_ready); end
            cyc();
        end
        #1;
        checks++; if (outst !== 3'd4) begin errors++; $display("FAIL fl_outst4: got %0d exp 4", outst); end
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL fl_blocked: got %b exp 0", h_o[0].a_ready); end
        checks++; if (d_o.a_valid !== 1'b0) begin errors++; $display("FAIL fl_dev_valid: got %b exp 0", d_o.a_valid); end
        cyc();
        d_i.d_valid = 1'b1;
        #1;
        checks++; if (h_o[0].a_ready !== 1'b0) begin errors++; $display("FAIL fl_pop_no_push: got %b exp 0", h_o[0].a_ready); end
        checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL fl_d_valid: got %b exp 1", h_o[0].d_valid); end
        cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd3) begin errors++; $display("FAIL fl_outst3: got %0d exp 3", outst); end
        checks++; if (h_o[0].a_ready !== 1'b1) begin errors++; $display("FAIL fl_reaccept: got %b exp 1", h_o[0].a_ready); end
        cyc();
        h_i[0].a_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd4) begin errors++; $display("FAIL fl_refull: got %0d exp 4", outst); end
        d_i.d_valid = 1'b1;
        repeat (4) cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL fl_drained: got %0d exp 0", outst); end
    endtask

    task automatic test_d_backpressure();
        h_i[0].a_valid = 1'b1;
        cyc();
        h_i[0].a_valid = 1'b0;
        h_i[1].a_valid = 1'b1;
        cyc();
        h_i[1].a_valid = 1'b0;
        h_i[0].d_ready = 1'b0;
        d_i.d_valid = 1'b1;
        #1;
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL bp_outst2: got %0d exp 2", outst); end
        checks++; if (d_o.d_ready !== 1'b0) begin errors++; $display("FAIL bp_dready0: got %b exp 0", d_o.d_ready); end
        checks++; if (h_o[0].d_valid !== 1'b1) begin errors++; $display("FAIL bp_h0_valid: got %b exp 1", h_o[0].d_valid); end
        checks++; if (h_o[1].d_valid !== 1'b0) begin errors++; $display("FAIL bp_h1_valid0: got %b exp 0", h_o[1].d_valid); end
        cyc();
        #1;
        checks++; if (d_o.d_ready !== 1'b0) begin errors++; $display("FAIL bp_dready1: got %b exp 0", d_o.d_ready); end
        checks++; if (h_o[1].d_valid !== 1'b0) begin errors++; $display("FAIL bp_h1_valid1: got %b exp 0", h_o[1].d_valid); end
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL bp_no_pop: got %0d exp 2", outst); end
        cyc();
        h_i[0].d_ready = 1'b1;
        #1;
        checks++; if (d_o.d_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b exp 1", d_o.d_ready); end
        cyc();
        #1;
        checks++; if (h_o[1].d_valid !== 1'b1) begin errors++; $display("FAIL bp_h1_beat: got %b exp 1", h_o[1].d_valid); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL bp_h0_done: got %b exp 0", h_o[0].d_valid); end
        checks++; if (outst !== 3'd1) begin errors++; $display("FAIL bp_outst1: got %0d exp 1", outst); end
        cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL bp_drained: got %0d exp 0", outst); end
    endtask

    task automatic test_spurious();
        d_i.d_valid = 1'b1;
        #1;
        checks++; if (spur !== 1'b1) begin errors++; $display("FAIL sp_pulse: got %b exp 1", spur); end
        checks++; if (d_o.d_ready !== 1'b1) begin errors++; $display("FAIL sp_drain: got %b exp 1", d_o.d_ready); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL sp_h0: got %b exp 0", h_o[0].d_valid); end
        checks++; if (h_o[1].d_valid !== 1'b0) begin errors++; $display("FAIL sp_h1: got %b exp 0", h_o[1].d_valid); end
        cyc();
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (spur !== 1'b0) begin errors++; $display("FAIL sp_end: got %b exp 0", spur); end
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL sp_outst: got %0d exp 0", outst); end
    endtask

    task automatic test_reset_mid();
        h_i[0].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        repeat (3) cyc();
        h_i[0].a_valid = 1'b0;
        h_i[1].a_valid = 1'b1;
        d_i.a_ready = 1'b0;
        #1;
        checks++; if (outst !== 3'd3) begin errors++; $display("FAIL rm_outst3: got %0d exp 3", outst); end
        checks++; if (d_o.a_source !== 8'h21) begin errors++; $display("FAIL rm_lock_src: got %0h exp 21", d_o.a_source); end
        cyc();
        rst_ni = 1'b0;
        h_i[0].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        d_i.d_valid = 1'b1;
        #1;
        checks++; if (d_o.a_valid !== 1'b0) begin errors++; $display("FAIL rm_a_valid: got %b exp 0", d_o.a_valid); end
        checks++; if (d_o.d_ready !== 1'b0) begin errors++; $display("FAIL rm_d_ready: got %b exp 0", d_o.d_ready); end
        checks++; if (h_o[1].a_ready !== 1'b0) begin errors++; $display("FAIL rm_h1_ready: got %b exp 0", h_o[1].a_ready); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rm_h0_dvalid: got %b exp 0", h_o[0].d_valid); end
        cyc();
        rst_ni = 1'b1;
        #1;
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL rm_outst0: got %0d exp 0", outst); end
        checks++; if (spur !== 1'b1) begin errors++; $display("FAIL rm_stale_spur: got %b exp 1", spur); end
        checks++; if (h_o[0].d_valid !== 1'b0) begin errors++; $display("FAIL rm_stale_h0: got %b exp 0", h_o[0].d_valid); end
        checks++; if (d_o.a_source !== 8'h10) begin errors++; $display("FAIL rm_idle_grant: got %0h exp 10", d_o.a_source); end
        cyc();
        h_i[0].a_valid = 1'b0;
        h_i[1].a_valid = 1'b0;
        d_i.d_valid = 1'b0;
    endtask

    initial begin
        h_i[0] = '0;
        h_i[1] = '0;
        d_i = '0;
        h_i[0].a_source = 8'h10;
        h_i[0].a_data = 32'h1000;
        h_i[1].a_source = 8'h21;
        h_i[1].a_data = 32'h2100;
        h_i[0].d_ready = 1'b1;
        h_i[1].d_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_d_backpressure();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
